// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall controller:
//   - pipe_state_e : controller state encoding (also exported on state_o)
//   - REG_SEL_W    : register-select width of decode/execute fields
//   - TMO_W        : memory timeout counter width
//   - FLUSH_CNT_W  : flush bubble counter width (FLUSH_CYCLES <= 15)
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_SEL_W   = 6;
  localparam int TMO_W       = 8;
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    MEM_WAIT = 3'd2,
    FLUSH    = 3'd3,
    LU_STALL = 3'd4
  } pipe_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_sat_counter
// Saturating event counter used for the optional performance counters.
// Ports:
//   clk     in      : clock
//   reset_n in      : asynchronous active-low reset, clears the count
//   inc     in      : count this cycle
//   cnt     out [W] : current count, sticks at all-ones
// ---------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Sequences the decode/execute pipeline latch: generates the latch enable,
// the bubble-insert select and the fetch enable; runs the memory request /
// ack handshake with a timeout; flushes decode after taken jumps and inserts
// a load-use bubble after loads.
//
// Optional build macro: PIPE_STALL_CTRL_PERF_EN adds the stall_cnt and
// flush_cnt performance counter ports.
//
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   dec_valid            : decode stage holds a valid instruction
//   dec_selA / dec_selB  : decode source registers (6 / 5 bits)
//   ex_selOut            : latched destination register, 0 = no writeback
//   ex_lam_new/_load     : latched instruction is a memory op / a load
//   ex_new_jmp/jmp_taken : latched instruction is a jump / resolved taken
//   mem_ack              : memory operation complete
//   mem_req              : registered memory request
//   fetch_en, dec_en     : fetch advance, decode latch load enable
//   dec_bubble           : zeros are muxed into the decode latch inputs
//   state_o              : current state (debug)
//   mem_timeout_err      : sticky timeout flag
//   stall_cnt, flush_cnt : perf counters (PIPE_STALL_CTRL_PERF_EN only)
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dec_valid,
  input  logic [REG_SEL_W-1:0] dec_selA,
  input  logic [REG_SEL_W-2:0] dec_selB,
  input  logic [REG_SEL_W-1:0] ex_selOut,
  input  logic                 ex_lam_new,
  input  logic                 ex_lam_load,
  input  logic                 ex_new_jmp,
  input  logic                 ex_jmp_taken,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 fetch_en,
  output logic                 dec_en,
  output logic                 dec_bubble,
  output logic [2:0]           state_o,
  output logic                 mem_timeout_err
`ifdef PIPE_STALL_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);

  // The jump cycle itself carries the first bubble, so FLUSH covers the rest.
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TMO_W-1:0]       TMO_LIMIT  = TMO_W'(MEM_TIMEOUT);

  pipe_state_e            r_state;
  pipe_state_e            w_state_next;
  logic                   r_mem_req;
  logic                   w_mem_req_next;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic [TMO_W-1:0]       w_tmo_cnt_next;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;
  logic [FLUSH_CNT_W-1:0] w_flush_cnt_next;
  logic                   r_tmo_err;
  logic                   w_tmo_err_next;

  logic w_fetch_en;
  logic w_dec_en;
  logic w_dec_bubble;
  logic w_jmp_taken;
  logic w_hazard;
  logic w_mem_done;

  assign w_jmp_taken = ex_new_jmp & ex_jmp_taken;

  // selB is one bit narrower than the destination field: zero-extend it so a
  // destination above 31 can never alias a selB value.
  assign w_hazard = ex_lam_load & dec_valid & (ex_selOut != '0) &
                    ((dec_selA == ex_selOut) | ({1'b0, dec_selB} == ex_selOut));

  // Ack and timeout in the same cycle count as an ack.
  assign w_mem_done = mem_ack | (r_tmo_cnt == TMO_LIMIT);

  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_tmo_cnt_next   = r_tmo_cnt;
    w_flush_cnt_next = r_flush_cnt;
    w_tmo_err_next   = r_tmo_err;
    w_fetch_en       = 1'b0;
    w_dec_en         = 1'b0;
    w_dec_bubble     = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_next = RUN;
      end

      RUN: begin
        w_fetch_en = 1'b1;
        w_dec_en   = 1'b1;
        if (w_jmp_taken) begin
          // A memory op arriving with a taken jump is squashed by the flush.
          w_dec_bubble     = 1'b1;
          w_flush_cnt_next = FLUSH_LOAD;
          w_state_next     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (ex_lam_new) begin
          w_fetch_en     = 1'b0;
          w_dec_en       = 1'b0;
          w_mem_req_next = 1'b1;
          w_tmo_cnt_next = '0;
          w_state_next   = MEM_WAIT;
        end
      end

      MEM_WAIT: begin
        w_tmo_cnt_next = r_tmo_cnt + 1'b1;
        if (w_mem_done) begin
          w_mem_req_next = 1'b0;
          if (!mem_ack) begin
            w_tmo_err_next = 1'b1;
          end
          if (w_hazard) begin
            // Advance execute with a bubble; the consumer stays in decode.
            w_dec_en     = 1'b1;
            w_dec_bubble = 1'b1;
            w_state_next = LU_STALL;
          end else begin
            w_fetch_en   = 1'b1;
            w_dec_en     = 1'b1;
            w_state_next = RUN;
          end
        end
      end

      FLUSH: begin
        w_fetch_en   = 1'b1;
        w_dec_en     = 1'b1;
        w_dec_bubble = 1'b1;
        if (w_jmp_taken) begin
          w_flush_cnt_next = FLUSH_LOAD;
        end else begin
          w_flush_cnt_next = r_flush_cnt - 1'b1;
          if (r_flush_cnt == FLUSH_CNT_W'(1)) begin
            w_state_next = RUN;
          end
        end
      end

      LU_STALL: begin
        w_state_next = RUN;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_flush_cnt <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_tmo_err   <= w_tmo_err_next;
    end
  end

  assign mem_req         = r_mem_req;
  assign fetch_en        = w_fetch_en;
  assign dec_en          = w_dec_en;
  assign dec_bubble      = w_dec_bubble;
  assign state_o         = r_state;
  assign mem_timeout_err = r_tmo_err;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic w_stall_inc;

  // IDLE also has dec_en low but is not a pipeline stall.
  assign w_stall_inc = (r_state != IDLE) & ~w_dec_en;

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (w_stall_inc),
    .cnt    (stall_cnt)
  );

  pipe_sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (w_dec_bubble),
    .cnt    (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Directed scenarios followed by randomized traffic. The stimulus process
// computes the expected outputs of every cycle from a behavioural model and
// queues them; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int F       = 2;
  localparam int TMO     = 4;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dec_valid;
  logic [5:0]    dec_selA;
  logic [4:0]    dec_selB;
  logic [5:0]    ex_selOut;
  logic          ex_lam_new;
  logic          ex_lam_load;
  logic          ex_new_jmp;
  logic          ex_jmp_taken;
  logic          mem_ack;
  logic          mem_req;
  logic          fetch_en;
  logic          dec_en;
  logic          dec_bubble;
  logic [2:0]    state_o;
  logic          mem_timeout_err;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .FLUSH_CYCLES(F),
    .MEM_TIMEOUT (TMO),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dec_valid      (dec_valid),
    .dec_selA       (dec_selA),
    .dec_selB       (dec_selB),
    .ex_selOut      (ex_selOut),
    .ex_lam_new     (ex_lam_new),
    .ex_lam_load    (ex_lam_load),
    .ex_new_jmp     (ex_new_jmp),
    .ex_jmp_taken   (ex_jmp_taken),
    .mem_ack        (mem_ack),
    .mem_req        (mem_req),
    .fetch_en       (fetch_en),
    .dec_en         (dec_en),
    .dec_bubble     (dec_bubble),
    .state_o        (state_o),
    .mem_timeout_err(mem_timeout_err)
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  typedef struct packed {
    logic       dec_valid;
    logic [5:0] selA;
    logic [4:0] selB;
    logic [5:0] selOut;
    logic       lam_new;
    logic       lam_load;
    logic       new_jmp;
    logic       jmp_taken;
    logic       mem_ack;
  } stim_t;

  typedef struct packed {
    logic          fe;
    logic          de;
    logic          bb;
    logic          mreq;
    logic          err;
    logic [2:0]    st;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Behavioural model: what the pipeline is currently doing, in plain terms.
  bit m_just_reset;   // first cycle after reset release
  bit m_lu_pending;   // one dead cycle owed for load-use writeback
  bit m_mem_busy;     // memory op outstanding, request is high
  int m_mem_age;      // cycles elapsed since the request rose
  int m_bubbles_left; // flush bubbles still owed after a taken jump
  bit m_err;
  int m_stall;
  int m_flush;

  function automatic void model_reset();
    m_just_reset   = 1'b1;
    m_lu_pending   = 1'b0;
    m_mem_busy     = 1'b0;
    m_mem_age      = 0;
    m_bubbles_left = 0;
    m_err          = 1'b0;
    m_stall        = 0;
    m_flush        = 0;
  endfunction

  function automatic void model_step(input stim_t s);
    exp_t e;
    bit   taken;
    bit   uses_load;
    taken     = s.new_jmp && s.jmp_taken;
    uses_load = s.lam_load && s.dec_valid && (s.selOut != 0) &&
                (int'(s.selA) == int'(s.selOut) || int'(s.selB) == int'(s.selOut));
    e       = '0;
    e.mreq  = m_mem_busy;
    e.err   = m_err;
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
    if (m_just_reset) begin
      e.st         = IDLE;
      m_just_reset = 1'b0;
    end else if (m_lu_pending) begin
      e.st         = LU_STALL;
      m_lu_pending = 1'b0;
    end else if (m_mem_busy) begin
      e.st = MEM_WAIT;
      if (s.mem_ack || m_mem_age == TMO) begin
        if (!s.mem_ack) m_err = 1'b1;
        m_mem_busy = 1'b0;
        if (uses_load) begin
          e.de = 1'b1; e.bb = 1'b1; m_lu_pending = 1'b1;
        end else begin
          e.fe = 1'b1; e.de = 1'b1;
        end
      end else begin
        m_mem_age++;
      end
    end else if (m_bubbles_left > 0) begin
      e.st = FLUSH;
      e.fe = 1'b1; e.de = 1'b1; e.bb = 1'b1;
      m_bubbles_left = taken ? F - 1 : m_bubbles_left - 1;
    end else begin
      e.st = RUN;
      if (taken) begin
        e.fe = 1'b1; e.de = 1'b1; e.bb = 1'b1;
        m_bubbles_left = F - 1;
      end else if (s.lam_new) begin
        m_mem_busy = 1'b1;
        m_mem_age  = 0;
      end else begin
        e.fe = 1'b1; e.de = 1'b1;
      end
    end
    if (e.st != IDLE && !e.de && m_stall < CNT_MAX) m_stall++;
    if (e.bb && m_flush < CNT_MAX) m_flush++;
    exp_q.push_back(e);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic apply(input stim_t s);
    dec_valid    = s.dec_valid;
    dec_selA     = s.selA;
    dec_selB     = s.selB;
    ex_selOut    = s.selOut;
    ex_lam_new   = s.lam_new;
    ex_lam_load  = s.lam_load;
    ex_new_jmp   = s.new_jmp;
    ex_jmp_taken = s.jmp_taken;
    mem_ack      = s.mem_ack;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk);
    #1;
    apply(s);
    cyc++;
    model_step(s);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply('0);
    cyc++;
    model_step('0);
  endtask

  // Assert reset mid-cycle (after the monitor has sampled) and verify the
  // outputs drop without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    apply('0);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_fetch_en", 32'(fetch_en), 32'd0);
    chk("rst_dec_en", 32'(dec_en), 32'd0);
    chk("rst_dec_bubble", 32'(dec_bubble), 32'd0);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    chk("rst_tmo_err", 32'(mem_timeout_err), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.dec_valid = ($urandom_range(0, 7) != 0);
    s.selOut    = 6'($urandom_range(0, 7));
    if ($urandom_range(0, 4) == 0) s.selOut[5] = 1'b1;
    s.selA      = ($urandom_range(0, 2) == 0) ? s.selOut : 6'($urandom_range(0, 7));
    s.selB      = ($urandom_range(0, 2) == 0) ? s.selOut[4:0] : 5'($urandom_range(0, 7));
    s.lam_new   = ($urandom_range(0, 5) == 0);
    s.lam_load  = 1'($urandom_range(0, 1));
    s.new_jmp   = ($urandom_range(0, 7) == 0);
    s.jmp_taken = 1'($urandom_range(0, 1));
    s.mem_ack   = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act_v;
    logic [7:0] req_v;
    if (exp_q.size() != 0) begin
      e     = exp_q.pop_front();
      act_v = {fetch_en, dec_en, dec_bubble, mem_req, mem_timeout_err, state_o};
      req_v = {e.fe, e.de, e.bb, e.mreq, e.err, e.st};
      vectors++;
      if (act_v !== req_v) begin
        miscompares++;
        $display("FAIL cyc%0d outputs {fe,de,bb,req,err,st}: got %b, expected %b",
                 cyc, act_v, req_v);
      end else begin
        $display("cyc %0d st=%0d fe=%b de=%b bb=%b req=%b err=%b",
                 cyc, state_o, fetch_en, dec_en, dec_bubble, mem_req, mem_timeout_err);
      end
`ifdef PIPE_STALL_CTRL_PERF_EN
      vectors++;
      if (stall_cnt !== e.stall || flush_cnt !== e.flush) begin
        miscompares++;
        $display("FAIL cyc%0d perf counters: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                 cyc, stall_cnt, flush_cnt, e.stall, e.flush);
      end
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    reset_n = 1'b0;
    apply('0);
    #3;
    chk("por_mem_req", 32'(mem_req), 32'd0);
    chk("por_state", 32'(state_o), 32'(IDLE));
    chk("por_enables", 32'({fetch_en, dec_en, dec_bubble}), 32'd0);
    chk("por_tmo_err", 32'(mem_timeout_err), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();

    // Settle into RUN.
    s = '0;
    repeat (2) drive(s);

    // Taken jump: two bubbles, then RUN. Then a not-taken jump.
    s = '0; s.new_jmp = 1'b1; s.jmp_taken = 1'b1;
    drive(s);
    s = '0;
    repeat (3) drive(s);
    s.new_jmp = 1'b1;
    drive(s);
    s = '0;
    drive(s);

    // Store with ack three cycles after the request rises.
    s = '0; s.lam_new = 1'b1;
    repeat (4) drive(s);
    s.mem_ack = 1'b1;
    drive(s);
    s = '0;
    repeat (2) drive(s);

    // Load to r5 consumed by decode: bubble on ack, one LU_STALL.
    s = '0; s.lam_new = 1'b1; s.lam_load = 1'b1; s.selOut = 6'd5;
    s.dec_valid = 1'b1; s.selA = 6'd5; s.selB = 5'd2;
    repeat (2) drive(s);
    s.mem_ack = 1'b1;
    drive(s);
    s = '0;
    repeat (2) drive(s);

    // Same load with no writeback destination: no stall.
    s = '0; s.lam_new = 1'b1; s.lam_load = 1'b1; s.selOut = 6'd0;
    s.dec_valid = 1'b1; s.selA = 6'd0; s.selB = 5'd0;
    repeat (2) drive(s);
    s.mem_ack = 1'b1;
    drive(s);
    s = '0;
    repeat (2) drive(s);

    // Destination 37 must not alias selB=5 (zero extension).
    s = '0; s.lam_new = 1'b1; s.lam_load = 1'b1; s.selOut = 6'd37;
    s.dec_valid = 1'b1; s.selA = 6'd1; s.selB = 5'd5;
    drive(s);
    s.mem_ack = 1'b1;
    drive(s);
    s = '0;
    repeat (2) drive(s);

    // No ack: forced completion, sticky error.
    s = '0; s.lam_new = 1'b1;
    drive(s);
    s = '0;
    repeat (8) drive(s);

    // Reset while waiting on memory.
    s = '0; s.lam_new = 1'b1;
    repeat (3) drive(s);
    do_reset();
    s = '0;
    repeat (2) drive(s);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (i % 373 == 372) do_reset();
      drive(rand_stim());
    end

    repeat (2) @(negedge clk);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

- Sequences the decode/execute pipeline latch.
- Generates that latch's `en`, a bubble-insert select, and the fetch enable.
- Services multi-cycle memory (lam) operations with a request/ack handshake and a timeout.
- Flushes the decode stage after taken jumps and inserts a load-use bubble after loads.
- Sits at the CPU top, between decoder outputs, the latched execute-stage fields and the memory interface.

## Interface
Clock is `clk`. Reset is `reset_n`: asynchronous, active-low.

Parameters:
- `FLUSH_CYCLES`, default 2: bubbles inserted after a taken jump, range 1–15.
- `MEM_TIMEOUT`, default 255: maximum MEM_WAIT cycles before forced completion, range 1–255.
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous active-low reset.
- `dec_valid` in 1: decode stage holds a valid instruction.
- `dec_selA` in 6: decode source A register.
- `dec_selB` in 5: decode source B register.
- `ex_selOut` in 6: latched destination register; 0 means no writeback.
- `ex_lam_new` in 1: latched instruction is a memory operation.
- `ex_lam_load` in 1: latched memory operation is a load.
- `ex_new_jmp` in 1: latched instruction is a jump.
- `ex_jmp_taken` in 1: jump resolved taken.
- `mem_ack` in 1: memory operation complete.
- `mem_req` out 1: memory request, registered.
- `fetch_en` out 1: fetch/PC advance enable.
- `dec_en` out 1: decode latch load enable.
- `dec_bubble` out 1: top muxes zeros into decode latch inputs.
- `state_o` out 3: current state, for debug.
- `mem_timeout_err` out 1: sticky timeout flag.
- `stall_cnt` out CNT_W: only with the Configuration macro.
- `flush_cnt` out CNT_W: only with the Configuration macro.

## Operation
States: IDLE, RUN, MEM_WAIT, FLUSH, LU_STALL.

IDLE
- Entered on reset.
- `fetch_en`/`dec_en`/`dec_bubble` = 0.
- Goes to RUN unconditionally on the next clock.

RUN
- Default outputs: `fetch_en`=1, `dec_en`=1, `dec_bubble`=0.
- Priority, highest first:
  - `ex_new_jmp & ex_jmp_taken`:
    - Outputs `dec_bubble`=1, `dec_en`=1, `fetch_en`=1.
    - Loads flush counter with FLUSH_CYCLES-1; goes to FLUSH. With FLUSH_CYCLES=1 it returns to RUN instead.
    - A simultaneous `ex_lam_new` is dropped.
  - `ex_lam_new`:
    - Outputs `fetch_en`=0, `dec_en`=0 (hold).
    - Sets `mem_req`; clears timeout counter; goes to MEM_WAIT.

MEM_WAIT
- Outputs `mem_req`=1 and hold.
- Timeout counter increments each cycle.
- On `mem_ack`, or on the counter reaching MEM_TIMEOUT:
  - Timeout path sets `mem_timeout_err`.
  - Clears `mem_req` on the next edge.
  - In that cycle, `fetch_en`=1 and `dec_en`=1.
  - Next state is LU_STALL if the hazard condition holds, else RUN.
- `mem_ack` and timeout in the same cycle are treated as an ack; the error flag is not set.

Load-use hazard
- Condition: `ex_lam_load & dec_valid & ex_selOut!=0 & (dec_selA==ex_selOut | {1'b0,dec_selB}==ex_selOut)`.
- When the hazard holds at ack, that cycle uses `fetch_en`=0, `dec_bubble`=1, `dec_en`=1 instead.
- The dependent instruction stays in decode.

LU_STALL
- One cycle with `fetch_en`=0 and `dec_en`=0, then RUN.
- Writeback lands during this cycle.

FLUSH
- Outputs `dec_bubble`=1, `dec_en`=1, `fetch_en`=1.
- Counter decrements each cycle; RUN when it reaches 0.
- A taken jump seen here reloads the counter, for robustness.

`mem_ack` outside MEM_WAIT is ignored.

## Timing
- Reset values:
  - state IDLE; `mem_req` 0; `fetch_en`, `dec_en`, `dec_bubble` 0; `mem_timeout_err` 0.
  - All counters 0; `state_o` 0 (IDLE encoding).
- First enable: one cycle after `reset_n` deasserts.
- Output decode:
  - `fetch_en`/`dec_en`/`dec_bubble` are combinational from state and inputs.
  - `mem_req` is a flop.
- Latencies:
  - Taken jump costs exactly FLUSH_CYCLES bubbles.
  - Memory op with ack N cycles after `mem_req` rises stalls N+1 cycles, plus 1 on load-use.
- Reset mid-operation: `mem_req` and all outputs drop asynchronously; a pending memory op is abandoned.

## Configuration
- `PIPE_STALL_CTRL_PERF_EN` defined:
  - `stall_cnt` counts cycles with `dec_en`=0 after IDLE.
  - `flush_cnt` counts cycles with `dec_bubble`=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - State enum: IDLE=0, RUN=1, MEM_WAIT=2, FLUSH=3, LU_STALL=4.
  - `REG_SEL_W`=6.
  - `TMO_W`=8.
- Sub-module `pipe_sat_counter` (parameter `W`; inputs `inc`, `clk`, `reset_n`; saturating output) provides both perf counters.

## Test plan
- Reset release: IDLE for 1 cycle, then RUN with `fetch_en`=`dec_en`=1, `dec_bubble`=0.
- Taken jump in RUN with FLUSH_CYCLES=2 -> `dec_bubble`=1 for exactly 2 cycles, then RUN; not-taken jump -> no bubble.
- `ex_lam_new`, `mem_ack` 3 cycles after `mem_req` rises -> `dec_en`=0 for 4 cycles, `mem_req` falls the cycle after ack.
- Load to r5, decode reads `dec_selA`=5 -> bubble on the ack cycle, one LU_STALL cycle, then RUN. Same with `ex_selOut`=0 -> no stall.
- No `mem_ack`, MEM_TIMEOUT=4 -> forced completion after 4 cycles, `mem_timeout_err`=1 and held until reset.
- Drop `reset_n` in MEM_WAIT -> `mem_req`=0 immediately, and IDLE then RUN after release.
